bin_to_bcd_serial: RTL and testbench
====================================

Name: bin_to_bcd_serial

Overview:
- Sequential double-dabble (shift-add-3) converter from an unsigned binary value to packed BCD digits.
- Sits directly upstream of the seven-segment display driver. It takes the bit-serial root result register and produces decimal digits for the display, replacing raw binary/hex display.
- Uses one shift iteration per clock, with a start/busy/done handshake. The displayed value changes only when a conversion completes.

Parameters:
- WIDTH, 8, bit width of the binary input i_Data.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1. Elaboration fails via a generate-time check if this is violated.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_Reset  input  1  asynchronous, active-low reset.
- i_Start  input  1  request a conversion; sampled on a rising edge of i_clk.
- i_Data  input  WIDTH  unsigned binary value; captured on the accepting edge only.
- o_Busy  output  1  high while a conversion is in progress.
- o_Done  output  1  one-cycle pulse when o_BCD has just been updated.
- o_BCD  output  4*DIGITS  packed BCD result, most significant digit in bits [4*DIGITS-1 -: 4].

Behaviour:
- Reset (i_Reset=0, asynchronous, any time including mid-conversion):
  - state=IDLE; o_Busy=0, o_Done=0, o_BCD=0.
  - Binary shift register, BCD scratch and counter all cleared.
  - Any in-flight conversion is discarded.
- Working registers:
  - Binary shift register: WIDTH bits.
  - BCD scratch: 4*DIGITS bits.
  - Iteration counter: $clog2(WIDTH+1) bits.
- State IDLE:
  - o_Busy=0.
  - If i_Start=1 at an edge: shift register <= i_Data, scratch <= 0, counter <= WIDTH, go to SHIFT, o_Busy <= 1.
- State SHIFT, one iteration per edge:
  - First, every scratch digit >= 5 gets +3 (digits evaluated in parallel, 4-bit add, no carry between digits).
  - Then {scratch, shift register} shifts left 1; the MSB of the shift register enters scratch bit 0.
  - counter <= counter-1.
- Completion, on the edge where counter goes 1->0:
  - o_BCD <= post-iteration scratch value.
  - o_Done <= 1, o_Busy <= 0, state <= IDLE.
- Latency:
  - i_Start sampled at edge N gives o_Done high during the cycle after edge N+WIDTH (9 edges for WIDTH=8).
  - Throughput: one conversion per WIDTH+1 cycles.
- o_Done:
  - Exactly one cycle wide; cleared on the next edge unconditionally.
  - Never asserted outside completion.
- i_Start while o_Busy=1: ignored. No queuing, no restart, no effect on the current conversion or on i_Data capture.
- i_Start in the cycle o_Done=1: accepted, since state is already IDLE. Back-to-back conversions are therefore allowed.
- o_BCD:
  - Holds the last completed result until the next completion; no intermediate values are ever visible.
  - Changes only on a completion edge or on reset.
- i_Data changes after the accepting edge have no effect on the current conversion.
- Value 0 converts normally (WIDTH iterations; result 0, o_Done still pulses).
- All arithmetic is unsigned. With the DIGITS rule satisfied, no overflow or truncation can occur.
- State encoding: 2 states (IDLE, SHIFT). No illegal-state lockup; an unreachable encoding returns to IDLE on the next edge.

Test Plan:
- Reset, then i_Start=1 for 1 cycle with i_Data=8'd255 -> o_Busy high for edges 1..8. o_Done=1 in exactly one cycle after edge 9 from the start sample. o_BCD=12'h255.
- i_Data=8'd0, then 8'd99, then 8'd128, each started after the previous o_Done -> o_BCD=12'h000, 12'h099, 12'h128 respectively, each with a single o_Done pulse and 9-edge latency.
- Start with i_Data=8'd200; pulse i_Start with i_Data=8'd7 at iteration 4 and change i_Data mid-run -> result 12'h200. Only one o_Done pulse, and o_Busy never drops early.
- Complete 8'd42 (o_BCD=12'h042); assert i_Start with i_Data=8'd255 in the o_Done cycle -> new conversion accepted immediately. o_BCD holds 12'h042 throughout, then becomes 12'h255 nine edges later.
- Start 8'd255; drive i_Reset=0 asynchronously between edges at iteration 5 -> o_Busy, o_Done, o_BCD all 0 immediately, without waiting for a clock edge. After release, no o_Done until a new i_Start. A fresh 8'd17 converts to 12'h017.
- Exhaustive sweep of i_Data 0..255 with back-to-back starts -> every o_BCD matches a reference decimal model. Every digit nibble <= 9.

Source files
------------

// File: rtl/bin_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_serial
//
// Sequential double-dabble (shift-add-3) converter. It turns an unsigned
// binary value into packed BCD digits for the seven-segment display driver.
// Each clock performs one shift iteration. The displayed value changes only
// when a conversion completes.
//
// Handshake: i_Start is sampled on a rising edge of i_clk. It is accepted
// only when the converter is idle (o_Busy=0). The o_Done cycle counts as
// idle, so back-to-back starts are legal. i_Data is captured on the
// accepting edge only. A start seen while busy is ignored. o_Busy is high
// from the accepting edge until the completion edge. On the completion edge
// o_BCD is loaded and o_Done pulses high for exactly one cycle.
//
// Parameters:
//   WIDTH   - bit width of i_Data
//   DIGITS  - number of BCD digits; 10**DIGITS must exceed 2**WIDTH-1
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_Reset  - asynchronous active-low reset
//   i_Start  - conversion request
//   i_Data   - unsigned binary value to convert
//   o_Busy   - conversion in progress
//   o_Done   - one-cycle pulse when o_BCD has just been updated
//   o_BCD    - packed BCD result; most significant digit in the top nibble
//   o_State  - current FSM state (0 = IDLE, 1 = SHIFT), for observation
// ---------------------------------------------------------------------------
module bin_to_bcd_serial #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic [WIDTH-1:0]      i_Data,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic [4*DIGITS-1:0]   o_BCD,
    output logic [0:0]            o_State
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    // Refuse to elaborate if the digit count cannot hold the largest input.
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_few
        $error("bin_to_bcd_serial: DIGITS too small for WIDTH");
    end

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [CW-1:0]         cnt;

    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   next_scratch;
    logic [WIDTH-1:0]      next_shreg;

    // Add-3 correction on every digit that is 5 or more, all digits in
    // parallel. Each digit uses its own 4-bit add with no carry between
    // digits. The correction is followed by one left shift of
    // {scratch, shreg}.
    always_comb begin
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        next_scratch = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
        next_shreg   = {shreg[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            o_Busy  <= 1'b0;
            o_Done  <= 1'b0;
            o_BCD   <= '0;
        end else begin
            // o_Done is a single-cycle pulse, so it is cleared by default.
            o_Done <= 1'b0;
            case (state)
                IDLE: begin
                    o_Busy <= 1'b0;
                    if (i_Start) begin
                        shreg   <= i_Data;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH);
                        o_Busy  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    shreg   <= next_shreg;
                    cnt     <= cnt - CW'(1);
                    // The last iteration publishes the post-shift scratch
                    // directly, so o_BCD never shows a partial value.
                    if (cnt == CW'(1)) begin
                        o_BCD  <= next_scratch;
                        o_Done <= 1'b1;
                        o_Busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign o_State = state;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_serial
//
// Self-checking bench for bin_to_bcd_serial with WIDTH=8 and DIGITS=3.
// Expected BCD values come from a decimal model. They are pushed to exp_q
// when a start is driven and popped when o_Done is seen.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_serial;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                 i_clk;
    logic                 i_Reset;
    logic                 i_Start;
    logic [WIDTH-1:0]     i_Data;
    logic                 o_Busy;
    logic                 o_Done;
    logic [4*DIGITS-1:0]  o_BCD;
    logic [0:0]           o_State;

    bin_to_bcd_serial #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .i_clk   (i_clk),
        .i_Reset (i_Reset),
        .i_Start (i_Start),
        .i_Data  (i_Data),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_BCD   (o_BCD),
        .o_State (o_State)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [4*DIGITS-1:0] exp_q[$];
    logic [4*DIGITS-1:0] last_bcd;
    logic [4*DIGITS-1:0] mon_exp;
    logic                prev_done;
    int                  n_checks;
    int                  n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Decimal reference: digits from division, independent of double-dabble.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // ---------------- monitor ----------------
    initial prev_done = 1'b0;

    always @(negedge i_clk) begin
        if (i_Reset && o_Done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'(o_Done), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("bcd", 32'(o_BCD), 32'(mon_exp));
                for (int d = 0; d < DIGITS; d++) begin
                    check("nibble_le9", 32'(o_BCD[4*d +: 4] <= 4'd9), 32'd1);
                end
            end
            if (prev_done) begin
                check("done_width", 32'(prev_done), 32'd0);
            end
        end
        prev_done <= o_Done;
    end

    // ---------------- driver ----------------
    // Call at a negedge. Drives one start, then checks busy, hold and latency.
    // It returns at the negedge where o_Done is expected.
    task automatic convert(input logic [WIDTH-1:0] data, input int interfere_at);
        i_Start = 1'b1;
        i_Data  = data;
        exp_q.push_back(to_bcd(int'(data)));
        @(posedge i_clk);
        #1;
        i_Start = 1'b0;
        i_Data  = 8'($urandom_range(0, 255));
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge i_clk);
            check("busy", 32'(o_Busy), 32'd1);
            check("done_early", 32'(o_Done), 32'd0);
            check("bcd_hold", 32'(o_BCD), 32'(last_bcd));
            if (i == interfere_at) begin
                i_Start = 1'b1;
                i_Data  = 8'd7;
            end else begin
                i_Start = 1'b0;
                i_Data  = 8'($urandom_range(0, 255));
            end
        end
        @(negedge i_clk);
        check("done", 32'(o_Done), 32'd1);
        check("busy_end", 32'(o_Busy), 32'd0);
        last_bcd = to_bcd(int'(data));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        last_bcd = '0;
        i_Reset  = 1'b0;
        i_Start  = 1'b0;
        i_Data   = '0;

        repeat (3) @(negedge i_clk);
        check("rst_busy", 32'(o_Busy), 32'd0);
        check("rst_done", 32'(o_Done), 32'd0);
        check("rst_bcd", 32'(o_BCD), 32'd0);
        check("rst_state", 32'(o_State), 32'd0);
        i_Reset = 1'b1;

        // Single conversion of the maximum value.
        @(negedge i_clk);
        convert(8'd255, -1);
        @(negedge i_clk);
        check("done_cleared", 32'(o_Done), 32'd0);

        // Separate conversions, each after the previous completion.
        @(negedge i_clk);
        convert(8'd0, -1);
        @(negedge i_clk);
        convert(8'd99, -1);
        @(negedge i_clk);
        convert(8'd128, -1);

        // A start while busy is ignored, and mid-run data changes do nothing.
        @(negedge i_clk);
        convert(8'd200, 3);
        @(negedge i_clk);
        check("ignored_start_no_done", 32'(o_Done), 32'd0);
        check("ignored_start_idle", 32'(o_Busy), 32'd0);

        // Back-to-back: a start in the o_Done cycle is accepted.
        @(negedge i_clk);
        convert(8'd42, -1);
        convert(8'd255, -1);

        // Asynchronous reset in the middle of a conversion.
        @(negedge i_clk);
        i_Start = 1'b1;
        i_Data  = 8'd255;
        @(posedge i_clk);
        #1;
        i_Start = 1'b0;
        repeat (5) @(posedge i_clk);
        #3;
        i_Reset = 1'b0;
        #1;
        check("arst_busy", 32'(o_Busy), 32'd0);
        check("arst_done", 32'(o_Done), 32'd0);
        check("arst_bcd", 32'(o_BCD), 32'd0);
        exp_q.delete();
        last_bcd = '0;
        repeat (3) @(negedge i_clk);
        i_Reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            check("post_rst_no_done", 32'(o_Done), 32'd0);
            check("post_rst_idle", 32'(o_Busy), 32'd0);
        end
        convert(8'd17, -1);

        // Exhaustive back-to-back sweep.
        @(negedge i_clk);
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), -1);
        end

        @(negedge i_clk);
        @(negedge i_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
